// File: rtl/perf_monitor_if.sv
// Retire-side bus into the performance monitor: one retiring instruction per cycle plus the pipeline stall flag.
interface perf_monitor_if;
  logic        retire_valid;
  logic [31:0] retire_inst;
  logic        stall;

  modport master (output retire_valid, retire_inst, stall);
  modport slave  (input  retire_valid, retire_inst, stall);
endinterface

// File: rtl/perf_monitor.sv
// Program-level performance monitor: per-class retire counters, cycle/stall counters and an IDLE/RUN/DRAIN/DONE sequencer.
// Optional stall counter enabled by defining PERF_STALL_CNT_EN; without it stall_cnt_o is tied to zero.
module perf_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 6,
  parameter logic [5:0]  HALT_OPCODE  = 6'b010001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  perf_monitor_if.slave    retire_if,
  output logic [CNT_W-1:0] arith_cnt_o,
  output logic [CNT_W-1:0] logic_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] ctrl_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o,
  output logic [CNT_W-1:0] total_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             sat_o,
  output logic             running_o,
  output logic             done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int unsigned    SUM_W      = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]     DRAIN_LAST = 8'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       drainCnt_q, drainCnt_d;
  logic [CNT_W-1:0] arithCnt_q, arithCnt_d;
  logic [CNT_W-1:0] logicCnt_q, logicCnt_d;
  logic [CNT_W-1:0] memCnt_q, memCnt_d;
  logic [CNT_W-1:0] ctrlCnt_q, ctrlCnt_d;
  logic [CNT_W-1:0] illegalCnt_q, illegalCnt_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] totalNext;

  logic [5:0] opcode;
  logic       isHalt, isArith, isLogic, isMem, isCtrl, isIllegal;
  logic       retireEn, cycleEn;
  logic       stallSat;
  logic [25:0] unusedInstBits;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] satSum(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                              input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d,
                                              input logic [CNT_W-1:0] e);
    logic [SUM_W-1:0] s;
    s = {3'b000, a} + {3'b000, b} + {3'b000, c} + {3'b000, d} + {3'b000, e};
    return (s > {3'b000, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign opcode         = retire_if.retire_inst[31:26];
  assign unusedInstBits = retire_if.retire_inst[25:0];

  // HALT is always counted as control, even if the opcode parameter is moved outside the ctrl range.
  always_comb begin
    isHalt    = (opcode == HALT_OPCODE);
    isArith   = !isHalt && (opcode <= 6'd5);
    isLogic   = !isHalt && (opcode >= 6'd6)  && (opcode <= 6'd11);
    isMem     = !isHalt && (opcode >= 6'd12) && (opcode <= 6'd13);
    isCtrl    =  isHalt || ((opcode >= 6'd14) && (opcode <= 6'd17));
    isIllegal = !isHalt && (opcode >= 6'd18);
  end

  assign retireEn = retire_if.retire_valid && ((state_q == IDLE) || (state_q == RUN));
  assign cycleEn  = (state_q == RUN) || (state_q == DRAIN) ||
                    ((state_q == IDLE) && retire_if.retire_valid);

  always_comb begin
    state_d      = state_q;
    drainCnt_d   = '0;
    arithCnt_d   = arithCnt_q;
    logicCnt_d   = logicCnt_q;
    memCnt_d     = memCnt_q;
    ctrlCnt_d    = ctrlCnt_q;
    illegalCnt_d = illegalCnt_q;
    cycleCnt_d   = cycleCnt_q;

    case (state_q)
      IDLE, RUN: begin
        if (retire_if.retire_valid) begin
          if (isHalt) state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          else        state_d = RUN;
        end
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + 8'd1;
        if (drainCnt_q == DRAIN_LAST) state_d = DONE;
      end
      default: state_d = state_q;
    endcase

    if (retireEn) begin
      if (isArith)   arithCnt_d   = satInc(arithCnt_q);
      if (isLogic)   logicCnt_d   = satInc(logicCnt_q);
      if (isMem)     memCnt_d     = satInc(memCnt_q);
      if (isCtrl)    ctrlCnt_d    = satInc(ctrlCnt_q);
      if (isIllegal) illegalCnt_d = satInc(illegalCnt_q);
    end
    if (cycleEn) cycleCnt_d = satInc(cycleCnt_q);

    totalNext = satSum(arithCnt_d, logicCnt_d, memCnt_d, ctrlCnt_d, illegalCnt_d);
    sat_d = sat_q | stallSat | (arithCnt_d == CNT_MAX) | (logicCnt_d == CNT_MAX) |
            (memCnt_d == CNT_MAX) | (ctrlCnt_d == CNT_MAX) | (illegalCnt_d == CNT_MAX) |
            (cycleCnt_d == CNT_MAX) | (totalNext == CNT_MAX);

    // Clear wins over anything else happening in the same cycle.
    if (clr_i) begin
      state_d      = IDLE;
      drainCnt_d   = '0;
      arithCnt_d   = '0;
      logicCnt_d   = '0;
      memCnt_d     = '0;
      ctrlCnt_d    = '0;
      illegalCnt_d = '0;
      cycleCnt_d   = '0;
      sat_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      drainCnt_q   <= '0;
      arithCnt_q   <= '0;
      logicCnt_q   <= '0;
      memCnt_q     <= '0;
      ctrlCnt_q    <= '0;
      illegalCnt_q <= '0;
      cycleCnt_q   <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drainCnt_q   <= drainCnt_d;
      arithCnt_q   <= arithCnt_d;
      logicCnt_q   <= logicCnt_d;
      memCnt_q     <= memCnt_d;
      ctrlCnt_q    <= ctrlCnt_d;
      illegalCnt_q <= illegalCnt_d;
      cycleCnt_q   <= cycleCnt_d;
      sat_q        <= sat_d;
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (cycleEn && retire_if.stall) stallCnt_d = satInc(stallCnt_q);
    if (clr_i) stallCnt_d = '0;
  end

  assign stallSat = !clr_i && (stallCnt_d == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallCnt_q <= '0;
    else      stallCnt_q <= stallCnt_d;
  end

  assign stall_cnt_o = stallCnt_q;
`else
  logic unusedStall;
  assign unusedStall = retire_if.stall;
  assign stallSat    = 1'b0;
  assign stall_cnt_o = '0;
`endif

  assign arith_cnt_o   = arithCnt_q;
  assign logic_cnt_o   = logicCnt_q;
  assign mem_cnt_o     = memCnt_q;
  assign ctrl_cnt_o    = ctrlCnt_q;
  assign illegal_cnt_o = illegalCnt_q;
  assign total_cnt_o   = satSum(arithCnt_q, logicCnt_q, memCnt_q, ctrlCnt_q, illegalCnt_q);
  assign cycle_cnt_o   = cycleCnt_q;
  assign sat_o         = sat_q;
  assign running_o     = (state_q == RUN) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: three instances (default, CNT_W=4, DRAIN_CYCLES=0) checked on done and on reset.
module tb_perf_monitor;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ANDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b000111;
  localparam logic [5:0] OP_LDW  = 6'b001100;
  localparam logic [5:0] OP_BZ   = 6'b001110;
  localparam logic [5:0] OP_HALT = 6'b010001;
  localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef PERF_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd3;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  typedef struct {
    string       name;
    logic [31:0] arithCnt, logicCnt, memCnt, ctrlCnt, illegalCnt, totalCnt, cycleCnt, stallCnt;
    logic        satFlag, runningFlag, doneFlag;
  } expRec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clrMain = 1'b0, clrSat = 1'b0, clrZero = 1'b0;
  int   checks = 0;
  int   failures = 0;

  expRec qMain[$];
  expRec qSat[$];
  expRec qZero[$];

  always #5 clk = ~clk;

  perf_monitor_if busMain();
  perf_monitor_if busSat();
  perf_monitor_if busZero();

  logic [31:0] aM, lM, mM, cM, iM, tM, cyM, sM;
  logic        satM, runM, doneM;
  logic [3:0]  aS, lS, mS, cS, iS, tS, cyS, sS;
  logic        satS, runS, doneS;
  logic [31:0] aZ, lZ, mZ, cZ, iZ, tZ, cyZ, sZ;
  logic        satZ, runZ, doneZ;

  perf_monitor dutMain (
    .clk(clk), .rst(rst), .clr_i(clrMain), .retire_if(busMain),
    .arith_cnt_o(aM), .logic_cnt_o(lM), .mem_cnt_o(mM), .ctrl_cnt_o(cM), .illegal_cnt_o(iM),
    .total_cnt_o(tM), .cycle_cnt_o(cyM), .stall_cnt_o(sM),
    .sat_o(satM), .running_o(runM), .done_o(doneM)
  );

  perf_monitor #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .clr_i(clrSat), .retire_if(busSat),
    .arith_cnt_o(aS), .logic_cnt_o(lS), .mem_cnt_o(mS), .ctrl_cnt_o(cS), .illegal_cnt_o(iS),
    .total_cnt_o(tS), .cycle_cnt_o(cyS), .stall_cnt_o(sS),
    .sat_o(satS), .running_o(runS), .done_o(doneS)
  );

  perf_monitor #(.DRAIN_CYCLES(0)) dutZero (
    .clk(clk), .rst(rst), .clr_i(clrZero), .retire_if(busZero),
    .arith_cnt_o(aZ), .logic_cnt_o(lZ), .mem_cnt_o(mZ), .ctrl_cnt_o(cZ), .illegal_cnt_o(iZ),
    .total_cnt_o(tZ), .cycle_cnt_o(cyZ), .stall_cnt_o(sZ),
    .sat_o(satZ), .running_o(runZ), .done_o(doneZ)
  );

  function automatic expRec mkExp(string name, int a, int l, int m, int c, int i, int t, int cy,
                                  logic [31:0] st, logic sat, logic run, logic dn);
    expRec e;
    e.name = name;
    e.arithCnt = 32'(a); e.logicCnt = 32'(l); e.memCnt = 32'(m); e.ctrlCnt = 32'(c);
    e.illegalCnt = 32'(i); e.totalCnt = 32'(t); e.cycleCnt = 32'(cy); e.stallCnt = st;
    e.satFlag = sat; e.runningFlag = run; e.doneFlag = dn;
    return e;
  endfunction

  function automatic expRec snap(int sel);
    expRec a;
    a.name = "dut";
    case (sel)
      0: begin
        a.arithCnt = aM; a.logicCnt = lM; a.memCnt = mM; a.ctrlCnt = cM; a.illegalCnt = iM;
        a.totalCnt = tM; a.cycleCnt = cyM; a.stallCnt = sM;
        a.satFlag = satM; a.runningFlag = runM; a.doneFlag = doneM;
      end
      1: begin
        a.arithCnt = 32'(aS); a.logicCnt = 32'(lS); a.memCnt = 32'(mS); a.ctrlCnt = 32'(cS);
        a.illegalCnt = 32'(iS); a.totalCnt = 32'(tS); a.cycleCnt = 32'(cyS); a.stallCnt = 32'(sS);
        a.satFlag = satS; a.runningFlag = runS; a.doneFlag = doneS;
      end
      default: begin
        a.arithCnt = aZ; a.logicCnt = lZ; a.memCnt = mZ; a.ctrlCnt = cZ; a.illegalCnt = iZ;
        a.totalCnt = tZ; a.cycleCnt = cyZ; a.stallCnt = sZ;
        a.satFlag = satZ; a.runningFlag = runZ; a.doneFlag = doneZ;
      end
    endcase
    return a;
  endfunction

  task automatic cmpField(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s.%s got=%0d want=%0d", tag, fld, got, want);
    end
  endtask

  task automatic checkOutput(input expRec e, input expRec a);
    cmpField(e.name, "arith",   a.arithCnt,   e.arithCnt);
    cmpField(e.name, "logic",   a.logicCnt,   e.logicCnt);
    cmpField(e.name, "mem",     a.memCnt,     e.memCnt);
    cmpField(e.name, "ctrl",    a.ctrlCnt,    e.ctrlCnt);
    cmpField(e.name, "illegal", a.illegalCnt, e.illegalCnt);
    cmpField(e.name, "total",   a.totalCnt,   e.totalCnt);
    cmpField(e.name, "cycle",   a.cycleCnt,   e.cycleCnt);
    cmpField(e.name, "stall",   a.stallCnt,   e.stallCnt);
    cmpField(e.name, "sat",     32'(a.satFlag),     32'(e.satFlag));
    cmpField(e.name, "running", 32'(a.runningFlag), 32'(e.runningFlag));
    cmpField(e.name, "done",    32'(a.doneFlag),    32'(e.doneFlag));
  endtask

  task automatic popAndCheck(input int sel, input string who);
    int n;
    n = (sel == 0) ? qMain.size() : (sel == 1) ? qSat.size() : qZero.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_unexpected got=output_event want=no_event", who);
    end else begin
      case (sel)
        0:       checkOutput(qMain.pop_front(), snap(0));
        1:       checkOutput(qSat.pop_front(),  snap(1));
        default: checkOutput(qZero.pop_front(), snap(2));
      endcase
    end
  endtask

  // Monitors: a rising done is the result presentation; reset is checked 1 ns into the pulse.
  logic prevDoneM = 1'b0, prevDoneS = 1'b0, prevDoneZ = 1'b0;
  always @(negedge clk) begin
    if (doneM === 1'b1 && prevDoneM !== 1'b1) popAndCheck(0, "main");
    if (doneS === 1'b1 && prevDoneS !== 1'b1) popAndCheck(1, "sat");
    if (doneZ === 1'b1 && prevDoneZ !== 1'b1) popAndCheck(2, "zero");
    prevDoneM = doneM;
    prevDoneS = doneS;
    prevDoneZ = doneZ;
  end

  always @(negedge rst) begin
    #1;
    popAndCheck(0, "mainReset");
  end

  task automatic applyStimulus(input int sel, input logic valid, input logic [5:0] op,
                               input logic stallIn, input logic clrIn);
    case (sel)
      0: begin busMain.retire_valid = valid; busMain.retire_inst = {op, 26'h2ABCDE}; busMain.stall = stallIn; clrMain = clrIn; end
      1: begin busSat.retire_valid  = valid; busSat.retire_inst  = {op, 26'h2ABCDE}; busSat.stall  = stallIn; clrSat  = clrIn; end
      default: begin busZero.retire_valid = valid; busZero.retire_inst = {op, 26'h2ABCDE}; busZero.stall = stallIn; clrZero = clrIn; end
    endcase
    @(posedge clk);
    #1;
    case (sel)
      0: begin busMain.retire_valid = 1'b0; busMain.stall = 1'b0; clrMain = 1'b0; end
      1: begin busSat.retire_valid  = 1'b0; busSat.stall  = 1'b0; clrSat  = 1'b0; end
      default: begin busZero.retire_valid = 1'b0; busZero.stall = 1'b0; clrZero = 1'b0; end
    endcase
  endtask

  task automatic waitResult(input int sel, input int budget, input string who);
    int n = 0;
    int pending;
    pending = (sel == 0) ? qMain.size() : (sel == 1) ? qSat.size() : qZero.size();
    while (pending != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      pending = (sel == 0) ? qMain.size() : (sel == 1) ? qSat.size() : qZero.size();
    end
    if (pending != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout got=pending:%0d want=pending:0", who, pending);
      case (sel)
        0:       qMain.delete();
        1:       qSat.delete();
        default: qZero.delete();
      endcase
    end
  endtask

  initial begin
    busMain.retire_valid = 1'b0; busMain.retire_inst = '0; busMain.stall = 1'b0;
    busSat.retire_valid  = 1'b0; busSat.retire_inst  = '0; busSat.stall  = 1'b0;
    busZero.retire_valid = 1'b0; busZero.retire_inst = '0; busZero.stall = 1'b0;

    qMain.push_back(mkExp("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3 rst = 1'b0;
    #5 rst = 1'b1;
    @(posedge clk);
    #1;
    waitResult(0, 2, "reset");

    qMain.push_back(mkExp("seq5", 1, 1, 1, 2, 0, 5, 11, 0, 0, 0, 1));
    applyStimulus(0, 1, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_ORI, 0, 0);
    applyStimulus(0, 1, OP_LDW, 0, 0);
    applyStimulus(0, 1, OP_BZ, 0, 0);
    applyStimulus(0, 1, OP_HALT, 0, 0);
    waitResult(0, 30, "seq5");
    applyStimulus(0, 0, OP_ADD, 0, 1);

    qMain.push_back(mkExp("illegal", 0, 0, 0, 1, 1, 2, 8, 0, 0, 0, 1));
    applyStimulus(0, 1, OP_BAD, 0, 0);
    applyStimulus(0, 1, OP_HALT, 0, 0);
    waitResult(0, 30, "illegal");
    applyStimulus(0, 0, OP_ADD, 0, 1);

    qMain.push_back(mkExp("clrRace", 1, 0, 0, 1, 0, 2, 8, 0, 0, 0, 1));
    applyStimulus(0, 1, OP_SUB, 0, 0);
    applyStimulus(0, 1, OP_SUB, 1, 1);
    applyStimulus(0, 0, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_SUB, 0, 0);
    applyStimulus(0, 1, OP_HALT, 0, 0);
    waitResult(0, 30, "clrRace");
    applyStimulus(0, 0, OP_ADD, 0, 1);

    qMain.push_back(mkExp("haltIdle", 0, 0, 0, 1, 0, 1, 7, 0, 0, 0, 1));
    applyStimulus(0, 1, OP_HALT, 0, 0);
    applyStimulus(0, 1, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_BAD, 0, 0);
    waitResult(0, 30, "haltIdle");
    applyStimulus(0, 0, OP_ADD, 0, 1);

    qSat.push_back(mkExp("satW4", 15, 0, 0, 1, 0, 15, 15, 0, 1, 0, 1));
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, OP_ADD, 0, 0);
    applyStimulus(1, 1, OP_HALT, 0, 0);
    waitResult(1, 30, "satW4");

    qZero.push_back(mkExp("stallZero", 2, 1, 1, 1, 0, 5, 8, STALL_EXP, 0, 0, 1));
    applyStimulus(2, 0, OP_ADD, 1, 0);
    applyStimulus(2, 1, OP_ADD, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(2, 0, OP_ADD, 1, 0);
    applyStimulus(2, 1, OP_ANDI, 0, 0);
    applyStimulus(2, 1, OP_LDW, 0, 0);
    applyStimulus(2, 1, OP_SUB, 0, 0);
    applyStimulus(2, 1, OP_HALT, 0, 0);
    waitResult(2, 10, "stallZero");

    applyStimulus(0, 1, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_HALT, 0, 0);
    applyStimulus(0, 0, OP_ADD, 0, 0);
    qMain.push_back(mkExp("rstDrain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    waitResult(0, 3, "rstDrain");

    qMain.push_back(mkExp("afterRst", 1, 0, 0, 1, 0, 2, 8, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_ADD, 0, 0);
    applyStimulus(0, 1, OP_HALT, 0, 0);
    waitResult(0, 30, "afterRst");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
